// File: rtl/debounce_arbiter.sv
// debounce_arbiter
//   Debounces N_BTN raw button levels with a single shared hold-time counter.
//   Pending buttons (synchronized level differs from the debounced level) are
//   served one at a time in round-robin order. A button must hold its new
//   level for DEBOUNCE_CYCLES clocks before the change is committed.
//
// Parameters
//   N_BTN            number of buttons (2..8)
//   DEBOUNCE_CYCLES  stable-level hold time in clocks (>= 2)
//   CNT_W            shared counter width; DEBOUNCE_CYCLES-1 must fit
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   Button     in   raw asynchronous button levels [N_BTN]
//   Stable     out  debounced levels [N_BTN]
//   Press      out  one-cycle pulse on a committed 0->1 change [N_BTN]
//   Release    out  one-cycle pulse on a committed 1->0 change [N_BTN]
//   Grant      out  one-hot owner of the counter, zero when idle [N_BTN]
//   Busy       out  FSM not in IDLE
//   Dbg_state  out  FSM state (0 IDLE, 1 COUNT, 2 COMMIT)
//
// Configuration
//   DEBOUNCE_ARBITER_RELEASE_EN  defined: Release pulses on 1->0 commits.
//                                undefined: Release is tied to zero; Stable
//                                still follows 1->0 commits.
//
// Handshake: none; Press/Release are unconditional single-cycle pulses.
module debounce_arbiter #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_W           = 25
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Button,
  output logic [N_BTN-1:0] Stable,
  output logic [N_BTN-1:0] Press,
  output logic [N_BTN-1:0] Release,
  output logic [N_BTN-1:0] Grant,
  output logic             Busy,
  output logic [1:0]       Dbg_state
);

  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BTN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_BTN-1:0]   sync1_q, sync2_q;
  logic [N_BTN-1:0]   stable_q, stable_d;
  logic [N_BTN-1:0]   press_q, press_d;
  logic [N_BTN-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef DEBOUNCE_ARBITER_RELEASE_EN
  logic [N_BTN-1:0]   release_q, release_d;
`endif

  logic [N_BTN-1:0]   pend;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_next;

  assign pend = sync2_q ^ stable_q;

  // Pointer moves past the button just served (commit or abort) so every
  // pending button is reached within N_BTN-1 windows.
  assign ptr_next = (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);

  // First pending index at or after ptr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!pick_found && pend[(int'(ptr_q) + k) % N_BTN]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(ptr_q) + k) % N_BTN);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= Button;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      stable_q <= '0;
      press_q  <= '0;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef DEBOUNCE_ARBITER_RELEASE_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      release_q <= '0;
    end else begin
      release_q <= release_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    press_d  = '0;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
`ifdef DEBOUNCE_ARBITER_RELEASE_EN
    release_d = '0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pick_found) begin
          grant_d = N_BTN'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        // A bounce back to the committed level wins over terminal count.
        if (sync2_q[gidx_q] == stable_q[gidx_q]) begin
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        stable_d[gidx_q] = ~stable_q[gidx_q];
        if (!stable_q[gidx_q]) begin
          press_d[gidx_q] = 1'b1;
        end
`ifdef DEBOUNCE_ARBITER_RELEASE_EN
        else begin
          release_d[gidx_q] = 1'b1;
        end
`endif
        grant_d = '0;
        cnt_d   = '0;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign Stable    = stable_q;
  assign Press     = press_q;
  assign Grant     = grant_q;
  assign Busy      = (state_q != S_IDLE);
  assign Dbg_state = state_q;
`ifdef DEBOUNCE_ARBITER_RELEASE_EN
  assign Release   = release_q;
`else
  assign Release   = '0;
`endif

endmodule
